// File: rtl/johnson_seq_ctrl.sv
// Step-count sequencer around a WIDTH-bit Johnson phase register: load a phase, advance N steps, pulse done.
// Optional feature: define JC_REVERSE_EN to let dir=1 step the register backwards during RUN.
module johnson_seq_ctrl #(
  parameter int  WIDTH = 4,
  parameter int  CW    = 8,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PW-1:0]    start_phase,
  input  logic [CW-1:0]    step_count,
  input  logic             en,
  input  logic             stop,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [PW-1:0]    phase_idx,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  localparam int            NPH     = 2*WIDTH;
  localparam logic [PW-1:0] PH_LAST = PW'(NPH-1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [PW-1:0]    ph_q;
  logic [PW-1:0]    start_ph_q;
  logic [CW-1:0]    step_q;
  logic [CW-1:0]    remaining_q;
  logic             busy_q;
  logic             done_q;
  logic             cfg_err_q;

  logic [WIDTH-1:0] q_adv;
  logic [PW-1:0]    ph_adv;
  logic             reverse;
  logic             ph_bad;

`ifdef JC_REVERSE_EN
  assign reverse = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign reverse    = 1'b0;
`endif

  // Only reachable when 2*WIDTH is not a power of two.
  assign ph_bad = (int'(start_phase) >= NPH);

  function automatic logic [WIDTH-1:0] pattern(input logic [PW-1:0] k);
    logic [WIDTH-1:0] p;
    int               kk;
    kk = int'(k);
    for (int i = 0; i < WIDTH; i++) begin
      p[i] = (kk < WIDTH) ? (i < kk) : (i >= kk - WIDTH);
    end
    return p;
  endfunction

  always_comb begin
    q_adv  = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    ph_adv = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    if (reverse) begin
      q_adv  = {~q_q[0], q_q[WIDTH-1:1]};
      ph_adv = (ph_q == '0) ? PH_LAST : ph_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      ph_q        <= '0;
      start_ph_q  <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            start_ph_q <= ph_bad ? '0 : start_phase;
            cfg_err_q  <= ph_bad;
            step_q     <= step_count;
          end
        end
        LOAD: begin
          q_q         <= pattern(start_ph_q);
          ph_q        <= start_ph_q;
          remaining_q <= step_q;
          cfg_err_q   <= 1'b0;
          if (step_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (en) begin
            q_q         <= q_adv;
            ph_q        <= ph_adv;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == CW'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q         = q_q;
  assign qbar      = ~q_q;
  assign phase_idx = ph_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule
